// File: rtl/img_stream_pkg.sv
// Shared types, pattern codes and timing helpers for the image stream generator.
package img_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE,
        ST_V_FRONT
    } state_t;

    localparam logic [1:0] PAT_EXT   = 2'd0;
    localparam logic [1:0] PAT_HRAMP = 2'd1;
    localparam logic [1:0] PAT_VRAMP = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    function automatic int h_total(input int hdisp, input int hblank);
        return hdisp + hblank;
    endfunction

    function automatic int v_total(input int vs, input int vb, input int vd, input int vf);
        return vs + vb + vd + vf;
    endfunction

    function automatic int max_lines(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/img_stream_timing.sv
// Frame timing FSM with pixel and line counters; produces raw sync/active strobes.
// state      | meaning
// ST_IDLE    | waiting for enable, counters held at 0
// ST_VSYNC   | sync lines, vs_int high
// ST_V_BACK  | blank lines before the first active line
// ST_ACTIVE  | active lines, hr_int high for the first IMG_HDISP clocks
// ST_V_FRONT | blank lines after the last active line; frame ends here
module img_stream_timing
    import img_stream_pkg::*;
#(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 20,
    parameter int V_FRONT     = 10,
    parameter int HW          = cnt_width(h_total(IMG_HDISP, H_BLANK)),
    parameter int LW          = cnt_width(max_lines(VSYNC_LINES, V_BACK, IMG_VDISP, V_FRONT))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          vs_int,
    output logic          hr_int,
    output logic [HW-1:0] x,
    output logic [LW-1:0] y,
    output logic          frame_start,
    output logic          frame_end,
    output logic          busy
);

    localparam int H_TOTAL = h_total(IMG_HDISP, H_BLANK);

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] h_cnt;
    logic [LW-1:0] line_cnt;
    logic          line_end;

    assign line_end = (h_cnt == HW'(H_TOTAL - 1));

    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nx    = ST_VSYNC;
                    frame_start = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (line_end && line_cnt == LW'(VSYNC_LINES - 1)) state_nx = ST_V_BACK;
            end
            ST_V_BACK: begin
                if (line_end && line_cnt == LW'(V_BACK - 1)) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (line_end && line_cnt == LW'(IMG_VDISP - 1)) state_nx = ST_V_FRONT;
            end
            ST_V_FRONT: begin
                if (line_end && line_cnt == LW'(V_FRONT - 1)) begin
                    frame_end = 1'b1;
                    // back-to-back frames restart immediately with no gap clocks
                    if (enable) begin
                        state_nx    = ST_VSYNC;
                        frame_start = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            h_cnt    <= '0;
            line_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE || line_end) h_cnt <= '0;
            else                               h_cnt <= h_cnt + 1'b1;
            if (state == ST_IDLE || state_nx != state) line_cnt <= '0;
            else if (line_end)                         line_cnt <= line_cnt + 1'b1;
        end
    end

    assign vs_int = (state == ST_VSYNC);
    assign hr_int = (state == ST_ACTIVE) && (h_cnt < HW'(IMG_HDISP));
    assign x      = h_cnt;
    assign y      = line_cnt;
    assign busy   = (state != ST_IDLE);

endmodule

// File: rtl/img_stream_gen.sv
// CMOS-style vsync/href/data stream source with external or built-in test-pattern pixels.
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 20,
    parameter int V_FRONT     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            pattern_mode,
    output logic                  src_rd_en,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  out_frame_vsync,
    output logic                  out_frame_href,
    output logic [DATA_WIDTH-1:0] out_img_data,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int HW = cnt_width(h_total(IMG_HDISP, H_BLANK));
    localparam int LW = cnt_width(max_lines(VSYNC_LINES, V_BACK, IMG_VDISP, V_FRONT));

    logic                  vs_int;
    logic                  hr_int;
    logic [HW-1:0]         x;
    logic [LW-1:0]         y;
    logic                  frame_start;
    logic                  frame_end;
    logic [1:0]            mode_r;
    logic [31:0]           x_ext;
    logic [31:0]           y_ext;
    logic [DATA_WIDTH-1:0] pat;
    logic [DATA_WIDTH-1:0] pat_r;
    logic                  href_r;
    logic                  vsync_r;

    img_stream_timing #(
        .IMG_HDISP  (IMG_HDISP),
        .IMG_VDISP  (IMG_VDISP),
        .H_BLANK    (H_BLANK),
        .VSYNC_LINES(VSYNC_LINES),
        .V_BACK     (V_BACK),
        .V_FRONT    (V_FRONT),
        .HW         (HW),
        .LW         (LW)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .vs_int     (vs_int),
        .hr_int     (hr_int),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy)
    );

    // widened so the checkerboard bit exists even for tiny counters
    assign x_ext = 32'(x);
    assign y_ext = 32'(y);

    always_comb begin
        pat = '0;
        case (mode_r)
            PAT_HRAMP: pat = DATA_WIDTH'(x_ext);
            PAT_VRAMP: pat = DATA_WIDTH'(y_ext);
            PAT_CHECK: pat = (x_ext[3] ^ y_ext[3]) ? '1 : '0;
            default:   pat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r  <= PAT_EXT;
            href_r  <= 1'b0;
            vsync_r <= 1'b0;
            pat_r   <= '0;
        end else begin
            if (frame_start) mode_r <= pattern_mode;
            href_r  <= hr_int;
            vsync_r <= vs_int;
            pat_r   <= hr_int ? pat : '0;
        end
    end

    assign src_rd_en       = hr_int && (mode_r == PAT_EXT);
    assign out_frame_href  = href_r;
    assign out_frame_vsync = vsync_r;
    // external pixel arrives one clock after the read, aligned with href_r
    assign out_img_data    = !href_r ? '0 : ((mode_r == PAT_EXT) ? src_data : pat_r);
    assign frame_done      = frame_end;

endmodule

// File: tb/tb_img_stream_gen.sv
// Self-checking bench for img_stream_gen against a line/pixel arithmetic reference model.
module tb_img_stream_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en8, en16;
    logic [1:0] pm8, pm16;
    logic [7:0] src8;
    logic [7:0] src16;
    logic       rd8, vs8, hr8, fd8, bz8;
    logic [7:0] d8;
    logic       rd16, vs16, hr16, fd16, bz16;
    logic [7:0] d16;
    int         rdc8;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    img_stream_gen #(
        .DATA_WIDTH(8), .IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(en8), .pattern_mode(pm8),
        .src_rd_en(rd8), .src_data(src8), .out_frame_vsync(vs8),
        .out_frame_href(hr8), .out_img_data(d8), .frame_done(fd8), .busy(bz8)
    );

    img_stream_gen #(
        .DATA_WIDTH(8), .IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut16 (
        .clk(clk), .rst(rst), .enable(en16), .pattern_mode(pm16),
        .src_rd_en(rd16), .src_data(src16), .out_frame_vsync(vs16),
        .out_frame_href(hr16), .out_img_data(d16), .frame_done(fd16), .busy(bz16)
    );

    assign src16 = 8'h00;

    // external source: returns 0xA0 + read index one clock after each read strobe
    always @(posedge clk) begin
        if (!bz8) rdc8 <= 0;
        else if (rd8) begin
            src8 <= 8'(32'hA0 + rdc8);
            rdc8 <= rdc8 + 1;
        end
    end

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s n=%0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // geometry: 1 vsync line, 1 back line, 4 active lines, 1 front line => 7 lines/frame
    function automatic bit m_hr(input int hd, input int t, input int total);
        int ht, p, l;
        ht = hd + 4;
        if (t < 0 || t >= total) return 1'b0;
        p = t % (7 * ht);
        l = p / ht;
        return (l >= 2 && l < 6 && (p % ht) < hd);
    endfunction

    function automatic bit m_vs(input int hd, input int t, input int total);
        int ht;
        ht = hd + 4;
        if (t < 0 || t >= total) return 1'b0;
        return ((t % (7 * ht)) / ht) == 0;
    endfunction

    function automatic bit m_fe(input int hd, input int t, input int total);
        int ft;
        ft = 7 * (hd + 4);
        if (t < 0 || t >= total) return 1'b0;
        return (t % ft) == ft - 1;
    endfunction

    function automatic logic [7:0] m_pat(input logic [1:0] mode, input int x, input int y);
        case (mode)
            2'd1:    return 8'(x);
            2'd2:    return 8'(y);
            2'd3:    return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // Starts a run from IDLE and checks every output each cycle; the mode of each frame is the
    // pattern_mode presented before that frame's start edge, and enable drops at drop_n.
    task automatic run_stream(input int hd, input int nfr, input logic [1:0] m0, input logic [1:0] m1,
                              input int chg_n, input int drop_n, input int tail);
        int ht, ft, total, rdk, t, dn, f, p;
        logic [1:0] mt, mn;
        logic eh, ehn;
        logic [7:0] ed;
        logic o_vs, o_hr, o_rd, o_fd, o_bz;
        logic [7:0] o_d;
        ht    = hd + 4;
        ft    = 7 * ht;
        total = nfr * ft;
        rdk   = 0;
        dn    = (drop_n >= 0) ? drop_n : (nfr - 1) * ft + 3;
        if (hd == 8) begin en8 = 1'b1; pm8 = m0; end
        else begin en16 = 1'b1; pm16 = m0; end
        for (int n = 0; n < total + tail; n++) begin
            @(negedge clk);
            if (hd == 8) begin
                o_vs = vs8; o_hr = hr8; o_d = d8; o_rd = rd8; o_fd = fd8; o_bz = bz8;
            end else begin
                o_vs = vs16; o_hr = hr16; o_d = d16; o_rd = rd16; o_fd = fd16; o_bz = bz16;
            end
            t  = n - 1;
            f  = (t < 0) ? 0 : t / ft;
            mt = (chg_n >= 0 && chg_n < f * ft) ? m1 : m0;
            f  = n / ft;
            mn = (chg_n >= 0 && chg_n < f * ft) ? m1 : m0;
            eh  = m_hr(hd, t, total);
            ehn = m_hr(hd, n, total);
            ed  = 8'h00;
            if (eh) begin
                p = t % ft;
                if (mt == 2'd0) begin
                    ed = 8'(32'hA0 + rdk);
                    rdk++;
                end else begin
                    ed = m_pat(mt, p % ht, p / ht - 2);
                end
            end
            chk("vsync", n, 32'(o_vs), 32'(m_vs(hd, t, total)));
            chk("href", n, 32'(o_hr), 32'(eh));
            chk("data", n, 32'(o_d), 32'(ed));
            chk("rd_en", n, 32'(o_rd), 32'(ehn && mn == 2'd0));
            chk("frame_done", n, 32'(o_fd), 32'(m_fe(hd, n, total)));
            chk("busy", n, 32'(o_bz), 32'(n < total));
            if (n == chg_n) begin
                if (hd == 8) pm8 = m1; else pm16 = m1;
            end
            if (n == dn) begin
                if (hd == 8) en8 = 1'b0; else en16 = 1'b0;
            end
        end
    endtask

    initial begin
        int r;
        logic [1:0] rm0, rm1;
        rst  = 1'b1;
        en8  = 1'b0;
        en16 = 1'b0;
        pm8  = 2'd0;
        pm16 = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_vsync", 0, 32'(vs8), 32'd0);
        chk("rst_href", 0, 32'(hr8), 32'd0);
        chk("rst_data", 0, 32'(d8), 32'd0);
        chk("rst_rd_en", 0, 32'(rd8), 32'd0);
        chk("rst_busy", 0, 32'(bz8), 32'd0);
        chk("rst_busy16", 0, 32'(bz16), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 0, 32'(bz8), 32'd0);
        chk("idle_vsync", 0, 32'(vs8), 32'd0);

        run_stream(8, 3, 2'd1, 2'd1, -1, -1, 10);               // H-ramp, back-to-back frames
        run_stream(8, 2, 2'd0, 2'd0, -1, -1, 10);               // external source
        run_stream(8, 1, 2'd2, 2'd2, -1, -1, 5);                // V-ramp
        run_stream(8, 1, 2'd3, 2'd3, -1, -1, 5);                // checkerboard, all zero
        run_stream(16, 1, 2'd3, 2'd3, -1, -1, 5);               // checkerboard, x>=8 is 0xFF
        run_stream(8, 1, 2'd1, 2'd1, -1, 36 + $urandom_range(0, 11), 30);  // enable drop
        run_stream(8, 2, 2'd1, 2'd2, $urandom_range(20, 70), -1, 5);       // mode change
        rm0 = 2'($urandom_range(0, 3));
        rm1 = 2'($urandom_range(0, 3));
        run_stream(8, 2, rm0, rm1, $urandom_range(1, 80), -1, 5);

        // reset mid-line with enable held high
        en8 = 1'b1;
        pm8 = 2'd1;
        r = 30 + $urandom_range(0, 20);
        repeat (r) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_vsync", r, 32'(vs8), 32'd0);
        chk("arst_href", r, 32'(hr8), 32'd0);
        chk("arst_data", r, 32'(d8), 32'd0);
        chk("arst_rd_en", r, 32'(rd8), 32'd0);
        chk("arst_frame_done", r, 32'(fd8), 32'd0);
        chk("arst_busy", r, 32'(bz8), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_stream(8, 1, 2'd1, 2'd1, -1, -1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
